inert_serf: RTL and testbench

Synthesizable SPI responder emulating the inertial sensor's register interface: the far end of the pitch/roll/yaw/accel readout link. It accepts 16-bit commands on SS_n/SCLK/MOSI, returns register bytes on MISO, holds the four config registers the initiator programs, and raises INT when a fresh sample is latched. Used as a sensor stand-in for full-system simulation and FPGA bring-up without a physical sensor.

---
 rtl/inert_pkg.sv | 36 +++
 rtl/spi_serf_shft.sv | 66 ++++++
 rtl/inert_serf.sv | 153 +++++++++++++++
 tb/tb_inert_serf.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial-sensor SPI responder.
// Register addresses are the 7-bit field carried in frame bits 14:8.
package inert_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CMPL} state_t;

    // Frame as held in the rx shift register once 16 bits are in.
    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    localparam logic [6:0] A_INT_CTRL = 7'h0D;
    localparam logic [6:0] A_WHO      = 7'h0F;
    localparam logic [6:0] A_CTRL1    = 7'h10;
    localparam logic [6:0] A_CTRL2    = 7'h11;
    localparam logic [6:0] A_CTRL5    = 7'h14;
    localparam logic [6:0] A_PTCH_L   = 7'h22;
    localparam logic [6:0] A_PTCH_H   = 7'h23;
    localparam logic [6:0] A_ROLL_L   = 7'h24;
    localparam logic [6:0] A_ROLL_H   = 7'h25;
    localparam logic [6:0] A_YAW_L    = 7'h26;
    localparam logic [6:0] A_YAW_H    = 7'h27;
    localparam logic [6:0] A_AX_L     = 7'h28;
    localparam logic [6:0] A_AX_H     = 7'h29;
    localparam logic [6:0] A_AY_L     = 7'h2A;
    localparam logic [6:0] A_AY_H     = 7'h2B;

    localparam logic [7:0] WHO_AM_I_DFLT = 8'h6A;
    localparam int         INT_EN_BIT    = 1;

    localparam logic [4:0] ADDR_BITS  = 5'd8;
    localparam logic [4:0] FRAME_BITS = 5'd16;

endpackage

// File: rtl/spi_serf_shft.sv
// SPI pin synchronizers, edge detection and the rx/tx shift datapath.
// The FSM in the top decides when to clear, load and enable tx shifting.
module spi_serf_shft
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        clr,
    input  logic        ld_tx,
    input  logic [7:0]  tx_byte,
    input  logic        shift_en,
    output logic        ss_fall,
    output logic        ss_rise,
    output logic [4:0]  cnt,
    output logic [15:0] rx,
    output logic        miso
);

    logic [2:0]  ss_q;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [15:0] tx;
    logic        sclk_rise;
    logic        sclk_fall;

    // Synchronizers are deliberately not reset: a select held low across
    // reset must not look like a fresh SS_n fall afterwards.
    always_ff @(posedge clk) begin
        ss_q   <= {ss_q[1:0], SS_n};
        sclk_q <= {sclk_q[1:0], SCLK};
        mosi_q <= {mosi_q[0], MOSI};
    end

    assign ss_fall   = ~ss_q[1] &  ss_q[2];
    assign ss_rise   =  ss_q[1] & ~ss_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx  <= '0;
            tx  <= '0;
            cnt <= '0;
        end else if (clr) begin
            rx  <= '0;
            tx  <= '0;
            cnt <= '0;
        end else begin
            // Counter saturates just past a full frame; bits beyond 16 are dropped.
            if (sclk_rise && cnt <= FRAME_BITS)
                cnt <= cnt + 5'd1;
            if (sclk_rise && cnt < FRAME_BITS)
                rx <= {rx[14:0], mosi_q[1]};
            if (ld_tx)
                tx <= {tx_byte, 8'h00};
            else if (sclk_fall && shift_en && cnt > ADDR_BITS)
                tx <= {tx[14:0], 1'b0};
        end
    end

    assign miso = tx[15];

endmodule

// File: rtl/inert_serf.sv
// Inertial sensor stand-in: SPI register responder with config registers,
// a latched sample bank and a data-ready interrupt.
module inert_serf
    import inert_pkg::*;
#(
    parameter bit         FAST_SIM = 1'b1,
    parameter logic [7:0] WHO_AM_I = WHO_AM_I_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic        smpl,
    input  logic [15:0] ptch_in,
    input  logic [15:0] roll_in,
    input  logic [15:0] yaw_in,
    input  logic [15:0] ax_in,
    input  logic [15:0] ay_in,
    output logic        dropped
);

    // FAST_SIM only exists so this block drops into the inertial path unchanged.
    if (!FAST_SIM) begin : g_full_rate
    end

    state_t      st, nxt;
    logic        ss_fall, ss_rise;
    logic [4:0]  cnt;
    logic [15:0] rx;
    logic        clr, ld_tx, commit;
    logic [7:0]  rd_byte;
    cmd_t        cmd;

    logic [7:0]       int_ctrl, ctrl1, ctrl2, ctrl5;
    logic [4:0][15:0] bank;
    logic             int_q;
    logic             smpl_ok;

    spi_serf_shft u_shft (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .clr      (clr),
        .ld_tx    (ld_tx),
        .tx_byte  (rd_byte),
        .shift_en (st == DATA),
        .ss_fall  (ss_fall),
        .ss_rise  (ss_rise),
        .cnt      (cnt),
        .rx       (rx),
        .miso     (MISO)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= nxt;
    end

    always_comb begin
        nxt    = st;
        clr    = 1'b0;
        ld_tx  = 1'b0;
        commit = 1'b0;
        case (st)
            IDLE: if (ss_fall) begin
                clr = 1'b1;
                nxt = ADDR;
            end
            ADDR: begin
                if (ss_rise)
                    nxt = IDLE;
                else if (cnt == ADDR_BITS) begin
                    ld_tx = 1'b1;
                    nxt   = DATA;
                end
            end
            DATA: if (ss_rise) nxt = (cnt >= FRAME_BITS) ? CMPL : IDLE;
            CMPL: begin
                commit = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // While in ADDR the low 7 bits of rx are the address just shifted in.
    always_comb begin
        rd_byte = 8'h00;
        case (rx[6:0])
            A_INT_CTRL: rd_byte = int_ctrl;
            A_WHO:      rd_byte = WHO_AM_I;
            A_CTRL1:    rd_byte = ctrl1;
            A_CTRL2:    rd_byte = ctrl2;
            A_CTRL5:    rd_byte = ctrl5;
            A_PTCH_L:   rd_byte = bank[0][7:0];
            A_PTCH_H:   rd_byte = bank[0][15:8];
            A_ROLL_L:   rd_byte = bank[1][7:0];
            A_ROLL_H:   rd_byte = bank[1][15:8];
            A_YAW_L:    rd_byte = bank[2][7:0];
            A_YAW_H:    rd_byte = bank[2][15:8];
            A_AX_L:     rd_byte = bank[3][7:0];
            A_AX_H:     rd_byte = bank[3][15:8];
            A_AY_L:     rd_byte = bank[4][7:0];
            A_AY_H:     rd_byte = bank[4][15:8];
            default:    rd_byte = 8'h00;
        endcase
    end

    assign cmd = cmd_t'(rx);

    // Only IDLE accepts samples, so a CMPL in the same cycle always wins
    // and the bank never moves while a frame is in flight.
    assign smpl_ok = smpl && int_ctrl[INT_EN_BIT] && !int_q && (st == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            int_ctrl <= '0;
            ctrl1    <= '0;
            ctrl2    <= '0;
            ctrl5    <= '0;
            bank     <= '0;
            int_q    <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= smpl && !smpl_ok;
            if (smpl_ok) begin
                bank  <= {ay_in, ax_in, yaw_in, roll_in, ptch_in};
                int_q <= 1'b1;
            end
            if (commit) begin
                if (!cmd.rd) begin
                    case (cmd.addr)
                        A_INT_CTRL: int_ctrl <= cmd.data;
                        A_CTRL1:    ctrl1    <= cmd.data;
                        A_CTRL2:    ctrl2    <= cmd.data;
                        A_CTRL5:    ctrl5    <= cmd.data;
                        default:    ;
                    endcase
                end else if (cmd.addr == A_AY_H) begin
                    int_q <= 1'b0;
                end
            end
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_inert_serf.sv
// Directed plus randomized bench for inert_serf against a flat byte-map model.
module tb_inert_serf;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        smpl = 1'b0;
    logic [15:0] ptch_in = '0, roll_in = '0, yaw_in = '0, ax_in = '0, ay_in = '0;
    logic        MISO, INT, dropped;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mdl [0:127];
    logic       mdl_int;

    always #10 clk = ~clk;

    inert_serf #(.FAST_SIM(1'b1), .WHO_AM_I(8'h6A)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT), .smpl(smpl),
        .ptch_in(ptch_in), .roll_in(roll_in), .yaw_in(yaw_in),
        .ax_in(ax_in), .ay_in(ay_in), .dropped(dropped)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
        mdl[7'h0F] = 8'h6A;
        mdl_int = 1'b0;
    endtask

    // One SPI frame of nbits; returns the 16 bits seen on MISO at SCLK rises.
    task automatic spi(input logic [15:0] cmd, input int nbits, output logic [15:0] w);
        w = '0;
        SS_n = 1'b0;
        wclk(HALF);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = cmd[15-i];
            wclk(HALF);
            SCLK = 1'b1;
            if (i < 16) w[15-i] = MISO;
            wclk(HALF);
        end
        SS_n = 1'b1;
        wclk(8);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] w;
        spi({1'b0, a, d}, 16, w);
        if (a == 7'h0D || a == 7'h10 || a == 7'h11 || a == 7'h14) mdl[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [6:0] a);
        logic [15:0] w;
        spi({1'b1, a, 8'h00}, 16, w);
        chk(tag, w, {8'h00, mdl[a]});
        if (a == 7'h2B) mdl_int = 1'b0;
        chk({tag, "_int"}, {15'd0, INT}, {15'd0, mdl_int});
    endtask

    task automatic do_smpl(input string tag, input logic [15:0] p, r, y, x, z);
        logic acc;
        ptch_in = p; roll_in = r; yaw_in = y; ax_in = x; ay_in = z;
        acc = mdl[7'h0D][1] && !mdl_int;
        smpl = 1'b1;
        wclk(1);
        smpl = 1'b0;
        if (acc) begin
            {mdl[7'h23], mdl[7'h22]} = p;
            {mdl[7'h25], mdl[7'h24]} = r;
            {mdl[7'h27], mdl[7'h26]} = y;
            {mdl[7'h29], mdl[7'h28]} = x;
            {mdl[7'h2B], mdl[7'h2A]} = z;
            mdl_int = 1'b1;
        end
        chk({tag, "_int"}, {15'd0, INT}, {15'd0, mdl_int});
        chk({tag, "_drop"}, {15'd0, dropped}, {15'd0, !acc});
        wclk(1);
        chk({tag, "_drop2"}, {15'd0, dropped}, 16'd0);
        wclk(2);
    endtask

    task automatic read_bank(input string tag);
        for (int a = 'h22; a <= 'h2B; a++) do_read(tag, 7'(a));
    endtask

    logic [6:0] wr_addrs [0:8] = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h22, 7'h2B, 7'h30, 7'h12};
    logic [6:0] rd_addrs [0:9] = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h14, 7'h22, 7'h27, 7'h2B, 7'h00, 7'h7F};

    initial begin
        logic [15:0] w;
        mdl_reset();
        wclk(4);
        chk("rst_miso", {15'd0, MISO}, 16'd0);
        chk("rst_int", {15'd0, INT}, 16'd0);
        chk("rst_drop", {15'd0, dropped}, 16'd0);
        rst_n = 1'b1;
        wclk(2);

        do_read("who", 7'h0F);

        do_write(7'h0D, 8'h02);
        do_write(7'h10, 8'h62);
        do_write(7'h11, 8'h62);
        do_write(7'h14, 8'h60);
        do_read("int_ctrl", 7'h0D);
        do_read("ctrl1", 7'h10);
        do_read("ctrl2", 7'h11);
        do_read("ctrl5", 7'h14);

        do_smpl("smpl1", 16'h1234, 16'hA5C3, 16'h0F0E, 16'h8001, 16'hFF80);
        read_bank("bank1");

        do_smpl("smpl2", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        do_smpl("smpl_busy", 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0BAD);
        read_bank("bank_busy");
        do_write(7'h0D, 8'h00);
        do_smpl("smpl_dis", 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333);
        read_bank("bank_dis");

        spi(16'h10AA, 10, w);
        do_read("abort", 7'h10);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(wr_addrs[$urandom_range(0, 8)], 8'($urandom));
                1: do_read("rnd_rd", rd_addrs[$urandom_range(0, 9)]);
                default: do_smpl("rnd_smpl", 16'($urandom), 16'($urandom), 16'($urandom),
                                 16'($urandom), 16'($urandom));
            endcase
        end
        read_bank("rnd_bank");

        // Reset in the middle of a read burst, select still low afterwards.
        do_write(7'h0D, 8'h02);
        if (mdl_int) do_read("pre_rst_clr", 7'h2B);
        do_smpl("pre_rst", 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A);
        SS_n = 1'b0;
        MOSI = 1'b1;
        wclk(HALF);
        for (int i = 0; i < 12; i++) begin
            SCLK = 1'b0; wclk(HALF); SCLK = 1'b1; wclk(HALF);
        end
        rst_n = 1'b0;
        wclk(3);
        chk("mid_rst_miso", {15'd0, MISO}, 16'd0);
        chk("mid_rst_int", {15'd0, INT}, 16'd0);
        chk("mid_rst_drop", {15'd0, dropped}, 16'd0);
        rst_n = 1'b1;
        mdl_reset();
        wclk(2);
        for (int i = 0; i < 6; i++) begin
            SCLK = 1'b0; wclk(HALF); SCLK = 1'b1; wclk(HALF);
        end
        SS_n = 1'b1;
        wclk(8);
        do_read("post_rst_who", 7'h0F);
        do_read("post_rst_ictl", 7'h0D);
        do_read("post_rst_ctrl1", 7'h10);
        do_read("post_rst_bank", 7'h22);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
